// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ valid/ready
// requesters, with a PREADY-stall watchdog and a one-cycle tagged response.
module apb_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR,
  input  logic [DATA_WIDTH-1:0]         PRDATA
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_gnt;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic [ID_W-1:0]       w_gnt;
  logic                  w_gnt_vld;
  logic [NUM_REQ-1:0]    w_ready;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [ID_W-1:0]       w_next_ptr;
  logic                  w_done;
  logic                  w_abort;

  // Index of the requester 'off' positions after 'base', wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(r_ptr, k)]) begin
        w_gnt     = rr_idx(r_ptr, k);
        w_gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == ST_IDLE && w_gnt_vld) w_ready[w_gnt] = 1'b1;
  end

  assign w_sel_addr  = req_addr[int'(w_gnt) * ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wdata[int'(w_gnt) * DATA_WIDTH +: DATA_WIDTH];
  assign w_next_ptr  = (r_gnt == ID_LAST) ? '0 : r_gnt + 1'b1;
  assign w_done      = PREADY;
  assign w_abort     = (TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_wait_cnt  <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_paddr   <= w_sel_addr;
            r_pwdata  <= w_sel_wdata;
            r_pwrite  <= req_write[w_gnt];
            r_gnt     <= w_gnt;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A watchdog abort reports an error with no data, like a failed completion.
          if (w_done || w_abort) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gnt;
            r_rsp_err   <= w_done ? PSLVERR : 1'b1;
            r_rsp_rdata <= (w_done && !r_pwrite) ? PRDATA : '0;
            r_ptr       <= w_next_ptr;
            r_state     <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level round-robin/APB reference model.
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic                  PCLK = 1'b0;
  logic                  PRESET = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_write = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [0:0]            rsp_id;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;
  logic                  PSEL, PENABLE, PWRITE;
  logic [AW-1:0]         PADDR;
  logic [DW-1:0]         PWDATA;
  logic                  PREADY = 1'b0;
  logic                  PSLVERR;
  logic [DW-1:0]         PRDATA;

  apb_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- APB slave: manual knobs or address-derived behaviour ----------------
  logic          s_auto = 1'b0;
  int            m_wait = 0;
  logic          m_err = 1'b0;
  logic          m_hang = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            acc_cnt = 0;

  function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic int auto_wait(input logic [AW-1:0] a);
    return int'(a[9:8]);
  endfunction
  function automatic logic auto_hang(input logic [AW-1:0] a);
    return a[15:12] == 4'hF;
  endfunction
  function automatic logic auto_err(input logic [AW-1:0] a);
    return a[4] & a[6];
  endfunction

  assign PRDATA  = s_auto ? hash(PADDR) : m_rdata;
  assign PSLVERR = s_auto ? auto_err(PADDR) : m_err;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (s_auto) PREADY = !auto_hang(PADDR) && (acc_cnt == auto_wait(PADDR));
      else        PREADY = !m_hang && (acc_cnt == m_wait);
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      acc_cnt = 0;
    end
  end

  // ---------------- common sequences ----------------
  task automatic do_reset();
    @(negedge PCLK);
    PRESET    = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic drive_req(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[id]           = 1'b1;
    req_write[id]           = wr;
    req_addr[id*AW +: AW]   = a;
    req_wdata[id*DW +: DW]  = d;
  endtask

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wt;
    logic          serr;
    logic          hang;
    logic [DW-1:0] srdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_psel;
    int            exp_pen;
  } vec_t;

  vec_t vecs[6];

  // One isolated transfer; latency counted in cycles from the accepting edge to the response.
  task automatic apply_vec(input vec_t v, input string tag);
    int lat, np, ne;
    bit got, bad;
    @(negedge PCLK);
    s_auto = 1'b0; m_wait = v.wt; m_err = v.serr; m_hang = v.hang; m_rdata = v.srdata;
    req_valid = '0;
    drive_req(v.id, v.wr, v.addr, v.wdata);
    #1 check({tag, "_ready"}, req_ready, oh(v.id));
    @(negedge PCLK);
    req_valid = '0;
    lat = 1; got = 0; np = 0; ne = 0; bad = 0;
    while (!got && lat <= 40) begin
      if (rsp_valid) got = 1;
      else begin
        if (PSEL) begin
          np++;
          if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata) bad = 1;
        end
        if (PENABLE) ne++;
        @(negedge PCLK);
        lat++;
      end
    end
    check({tag, "_rsp_seen"}, got, 1);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_rsp_id"}, rsp_id, v.id);
    check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, "_rsp_err"}, rsp_err, v.exp_err);
    check({tag, "_psel_cycles"}, np, v.exp_psel);
    check({tag, "_penable_cycles"}, ne, v.exp_pen);
    check({tag, "_apb_fields_stable"}, bad, 0);
    @(negedge PCLK);
    check({tag, "_rsp_pulse_end"}, rsp_valid, 0);
    check({tag, "_rsp_rdata_hold"}, rsp_rdata, v.exp_rdata);
  endtask

  // ---------------- transaction-level engine with reference model ----------------
  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  int obs_id[$];
  int obs_cyc[$];

  task automatic run_engine(input int n_each, input bit rnd);
    int            cyc, busy_until, last, g_cyc, done_cyc, pick, lat;
    int            remaining[NUM_REQ];
    bit            have[NUM_REQ];
    logic          wr[NUM_REQ];
    logic [AW-1:0] ad[NUM_REQ];
    logic [DW-1:0] wd[NUM_REQ];
    logic [NUM_REQ-1:0] cons;
    logic [AW-1:0] x_addr;
    logic          x_wr, hang, exp_rsp, exp_psel;
    logic [DW-1:0] x_wd;
    exp_t          expq[$];
    bit            fin, idle_all;
    cyc = 0; busy_until = 0; last = NUM_REQ - 1; g_cyc = -100; done_cyc = -100;
    cons = '0; fin = 0; x_addr = '0; x_wr = 1'b0; x_wd = '0;
    obs_id.delete(); obs_cyc.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = n_each; have[i] = 0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    s_auto = 1'b1;
    while (!fin) begin
      @(negedge PCLK);
      cyc++;
      exp_rsp = (expq.size() > 0) && (expq[0].cyc == cyc);
      if (rsp_valid || exp_rsp) check("eng_rsp_valid", rsp_valid, exp_rsp);
      if (rsp_valid && exp_rsp) begin
        check("eng_rsp_id", rsp_id, expq[0].id);
        check("eng_rsp_rdata", rsp_rdata, expq[0].rdata);
        check("eng_rsp_err", rsp_err, expq[0].err);
      end
      if (exp_rsp) void'(expq.pop_front());
      exp_psel = (cyc > g_cyc) && (cyc < done_cyc);
      check("eng_psel", PSEL, exp_psel);
      check("eng_penable", PENABLE, (cyc > g_cyc + 1) && (cyc < done_cyc));
      if (exp_psel) begin
        check("eng_paddr", PADDR, x_addr);
        check("eng_pwrite", PWRITE, x_wr);
        check("eng_pwdata", PWDATA, x_wd);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cons[i]) begin
          have[i] = 0;
          remaining[i]--;
        end else if (rnd && have[i] && $urandom_range(0, 9) == 0) begin
          have[i] = 0;
        end
        if (!have[i] && remaining[i] > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
          have[i] = 1;
          if (rnd) begin
            ad[i] = $urandom;
            if ($urandom_range(0, 15) == 0) ad[i][15:12] = 4'hF;
            else if (ad[i][15:12] == 4'hF) ad[i][15] = 1'b0;
            wr[i] = 1'($urandom_range(0, 1));
            wd[i] = $urandom;
          end else begin
            ad[i] = 32'h1000 * (n_each - remaining[i]) + 32'h10 * i;
            wr[i] = (i == 0);
            wd[i] = 32'hA000_0000 + i;
          end
        end
        req_valid[i] = have[i];
        req_write[i] = wr[i];
        req_addr[i*AW +: AW]  = ad[i];
        req_wdata[i*DW +: DW] = wd[i];
      end
      #1;
      pick = -1;
      if (cyc >= busy_until) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (last + k) % NUM_REQ;
          if (pick < 0 && have[c]) pick = c;
        end
      end
      check("eng_req_ready", req_ready, (pick >= 0) ? oh(pick) : '0);
      if (req_ready != '0) begin
        int b;
        b = 0;
        for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) b = j;
        obs_id.push_back(b);
        obs_cyc.push_back(cyc);
      end
      cons = '0;
      if (pick >= 0) begin
        hang = auto_hang(ad[pick]);
        lat  = hang ? 2 + TIMEOUT : 3 + auto_wait(ad[pick]);
        expq.push_back('{cyc + lat, pick,
                         (hang || wr[pick]) ? '0 : hash(ad[pick]),
                         hang ? 1'b1 : auto_err(ad[pick])});
        busy_until = cyc + lat;
        g_cyc      = cyc;
        done_cyc   = cyc + lat;
        x_addr = ad[pick]; x_wr = wr[pick]; x_wd = wd[pick];
        last       = pick;
        cons[pick] = 1'b1;
      end
      idle_all = (expq.size() == 0);
      for (int i = 0; i < NUM_REQ; i++) if (have[i] || remaining[i] > 0) idle_all = 0;
      fin = idle_all;
      if (cyc > 20000) begin
        check("eng_cycle_bound", 0, 1);
        fin = 1;
      end
    end
    req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit saw_rsp;
    vecs[0] = '{0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hAAAA_5555, 32'h0,          1'b0, 3,  2,  1};
    vecs[1] = '{1, 1'b0, 32'h20, 32'h1111_2222, 3, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 6,  5,  4};
    vecs[2] = '{0, 1'b0, 32'h30, 32'h0,         0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 3,  2,  1};
    vecs[3] = '{1, 1'b1, 32'h44, 32'h0BAD_CAFE, 1, 1'b1, 1'b0, 32'h9999_9999, 32'h0,          1'b1, 4,  3,  2};
    vecs[4] = '{0, 1'b0, 32'h50, 32'h0,         0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,          1'b1, 18, 17, 16};
    vecs[5] = '{1, 1'b0, 32'h60, 32'h0,         0, 1'b0, 1'b0, 32'h0102_0304, 32'h0102_0304, 1'b0, 3,  2,  1};

    // Reset state
    do_reset();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 0);

    // Directed single transfers: write, waited read, slave error, write error, timeout, recovery
    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Contention from reset: alternating grants, one every 3 cycles
    do_reset();
    run_engine(2, 1'b0);
    check("cont_grants", obs_id.size(), 4);
    for (int i = 0; i < obs_id.size() && i < 4; i++) begin
      check($sformatf("cont_order%0d", i), obs_id[i], i % 2);
      if (i > 0) check($sformatf("cont_gap%0d", i), obs_cyc[i] - obs_cyc[i-1], 3);
    end

    // Reset during ACCESS: no response, bus idle, pointer back to requester 0
    do_reset();
    apply_vec('{0, 1'b0, 32'h70, 32'h0, 0, 1'b0, 1'b0, 32'h7777_0001, 32'h7777_0001, 1'b0, 3, 2, 1}, "prerst");
    @(negedge PCLK);
    m_hang = 1'b1;
    drive_req(1, 1'b0, 32'h80, 32'h0);
    #1 check("midrst_ready1", req_ready, oh(1));
    @(negedge PCLK);
    req_valid = '0;
    @(negedge PCLK);
    check("midrst_in_access", PENABLE, 1);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("midrst_psel", PSEL, 0);
    check("midrst_penable", PENABLE, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    saw_rsp = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (rsp_valid) saw_rsp = 1;
    end
    check("midrst_no_rsp", saw_rsp, 0);
    drive_req(0, 1'b0, 32'h90, 32'h0);
    drive_req(1, 1'b0, 32'hA0, 32'h0);
    #1 check("midrst_ptr_reset", req_ready, oh(0));
    req_valid = '0;

    // Randomized traffic with gaps, withdrawals, waits, errors and timeouts
    do_reset();
    run_engine(60, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
